// File: rtl/minimax_bus_pkg.sv
// Shared definitions for the minimax data-bus target: MMIO defaults, decode regions,
// read-pipeline states.
package minimax_bus_pkg;

  localparam logic [31:0] CON_ADDR_DEF  = 32'hFFFF_FFF8;
  localparam logic [31:0] HALT_ADDR_DEF = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    RGN_NONE = 2'd0,
    RGN_RAM  = 2'd1,
    RGN_CON  = 2'd2,
    RGN_HALT = 2'd3
  } region_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

  // MMIO words match on the word address only; the RAM bound is byte-granular.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [31:0] con_addr,
                                            input logic [31:0] halt_addr);
    region_e rgn;
    rgn = RGN_NONE;
    if (addr < ram_bytes)
      rgn = RGN_RAM;
    else if (addr[31:2] == con_addr[31:2])
      rgn = RGN_CON;
    else if (addr[31:2] == halt_addr[31:2])
      rgn = RGN_HALT;
    return rgn;
  endfunction

endpackage

// File: rtl/minimax_sync_fifo.sv
// Single-clock FIFO for the console path. A pop frees a slot for a push in the same
// cycle; an empty FIFO never bypasses write data to its head.
module minimax_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/minimax_dbus_target.sv
// Data-bus responder for the minimax core: byte-writable RAM, console FIFO word,
// halt/exit-code word, with a fixed-latency read acknowledge.
//
// state   | meaning
// RD_IDLE | no read outstanding; an accepted rreq captures data this cycle
// RD_WAIT | read captured, down-counting to the rack pulse
module minimax_dbus_target
  import minimax_bus_pkg::*;
#(
  parameter int unsigned RAM_WORDS    = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CON_DEPTH    = 4,
  parameter logic [31:0] CON_ADDR     = CON_ADDR_DEF,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        rreq,
  output logic [31:0] rdata,
  output logic        rack,
  output logic [31:0] con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        overflow,
  output logic        bus_err
);

  localparam int unsigned RamAw   = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned ConCntW = $clog2(CON_DEPTH) + 1;
  localparam logic [1:0]  LatInit = 2'(READ_LATENCY - 1);

  region_e            region;
  logic               wr_en;
  logic [RamAw-1:0]   ram_idx;
  logic [3:0][7:0]    mem_q [RAM_WORDS];
  logic [31:0]        rd_val;

  rd_state_e          state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               rack_q, rack_d;
  logic [31:0]        cap_q, cap_d;
  logic               rd_accept;

  logic               halt_q, halt_code_en;
  logic [31:0]        halt_code_q;
  logic               overflow_q, bus_err_q;

  logic               con_push, con_full, con_empty;
  logic [ConCntW-1:0] con_count;

  assign region  = decode_region(addr, 32'(4 * RAM_WORDS), CON_ADDR, HALT_ADDR);
  assign wr_en   = |wmask;
  assign ram_idx = addr[RamAw+1:2];

  always_ff @(posedge clk) begin
    if (wr_en && region == RGN_RAM) begin
      for (int l = 0; l < 4; l++) begin
        if (wmask[l]) mem_q[ram_idx][l] <= wdata[8*l +: 8];
      end
    end
  end

  // Sampled before this cycle's write lands, so a same-cycle read sees old data.
  always_comb begin
    rd_val = '0;
    case (region)
      RGN_RAM:  rd_val = mem_q[ram_idx];
      RGN_CON:  rd_val = {16'h0, 8'(con_count), 7'h0, overflow_q};
      RGN_HALT: rd_val = halt_code_q;
      default:  rd_val = '0;
    endcase
  end

  // At latency 1 the FSM never leaves IDLE, so a new rreq during rack is a legal
  // back-to-back read; at longer latencies the rack cycle still belongs to the old read.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rack_d    = 1'b0;
    cap_d     = cap_q;
    rd_accept = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rreq && (READ_LATENCY == 1 || !rack_q)) begin
          rd_accept = 1'b1;
          cap_d     = rd_val;
          cnt_d     = LatInit;
          if (LatInit == 2'd0) rack_d = 1'b1;
          else                 state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_d == 2'd0) begin
          rack_d  = 1'b1;
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RD_IDLE;
      cnt_q   <= '0;
      rack_q  <= 1'b0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rack_q  <= rack_d;
      cap_q   <= cap_d;
    end
  end

  assign con_push     = wr_en && region == RGN_CON && wmask == 4'hF;
  assign halt_code_en = wr_en && region == RGN_HALT && wmask == 4'hF && !halt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      overflow_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if (halt_code_en) begin
        halt_q      <= 1'b1;
        halt_code_q <= wdata;
      end
      if (con_push && con_full && !con_ready) overflow_q <= 1'b1;
      if (region == RGN_NONE && (wr_en || rd_accept)) bus_err_q <= 1'b1;
    end
  end

  minimax_sync_fifo #(
    .WIDTH (32),
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (con_push),
    .data_i  (wdata),
    .pop_i   (con_ready),
    .data_o  (con_data),
    .full_o  (con_full),
    .empty_o (con_empty),
    .count_o (con_count)
  );

  assign con_valid = ~con_empty;
  assign rack      = rack_q;
  assign rdata     = rack_q ? cap_q : 32'h0;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;
  assign overflow  = overflow_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_minimax_dbus_target.sv
// Directed bench: three targets at read latencies 1, 3 and 4 share one bus.
module tb_minimax_dbus_target;

  localparam logic [31:0] CON  = 32'hFFFF_FFF8;
  localparam logic [31:0] HLT  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr, wdata;
  logic [3:0]  wmask;
  logic        rreq, con_ready;

  logic [31:0] rdata1, con_data1, halt_code1;
  logic        rack1, con_valid1, halt1, overflow1, bus_err1;
  logic [31:0] rdata3, con_data3, halt_code3;
  logic        rack3, con_valid3, halt3, overflow3, bus_err3;
  logic [31:0] rdata4, con_data4, halt_code4;
  logic        rack4, con_valid4, halt4, overflow4, bus_err4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  minimax_dbus_target #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .wmask(wmask), .rreq(rreq),
    .rdata(rdata1), .rack(rack1), .con_data(con_data1), .con_valid(con_valid1),
    .con_ready(con_ready), .halt(halt1), .halt_code(halt_code1), .overflow(overflow1),
    .bus_err(bus_err1));

  minimax_dbus_target #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .wmask(wmask), .rreq(rreq),
    .rdata(rdata3), .rack(rack3), .con_data(con_data3), .con_valid(con_valid3),
    .con_ready(con_ready), .halt(halt3), .halt_code(halt_code3), .overflow(overflow3),
    .bus_err(bus_err3));

  minimax_dbus_target #(.READ_LATENCY(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .wmask(wmask), .rreq(rreq),
    .rdata(rdata4), .rack(rack4), .con_data(con_data4), .con_valid(con_valid4),
    .con_ready(con_ready), .halt(halt4), .halt_code(halt_code4), .overflow(overflow4),
    .bus_err(bus_err4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; wmask = m; rreq = 1'b0;
    cyc();
    wmask = 4'h0;
  endtask

  // Single read seen through the latency-1 target; extra cycles let the slower targets drain.
  task automatic rd1(input logic [31:0] a, output logic [31:0] v, output logic ack);
    addr = a; rreq = 1'b1;
    cyc();
    rreq = 1'b0;
    ack = rack1;
    v   = rdata1;
    repeat (4) cyc();
  endtask

  logic [31:0] v, v3, v4;
  logic        ack;
  int          n3, n4, p1, p3, p4;

  initial begin
    reset_n = 1'b0; addr = '0; wdata = '0; wmask = '0; rreq = 1'b0; con_ready = 1'b0;
    cyc(); cyc();
    check("rst_rack",      {31'b0, rack1}, 32'h0);
    check("rst_rdata",     rdata1, 32'h0);
    check("rst_con_valid", {31'b0, con_valid1}, 32'h0);
    check("rst_halt",      {31'b0, halt1}, 32'h0);
    check("rst_halt_code", halt_code1, 32'h0);
    check("rst_overflow",  {31'b0, overflow1}, 32'h0);
    check("rst_bus_err",   {31'b0, bus_err1}, 32'h0);
    reset_n = 1'b1;
    cyc();

    // 1: full write then latency-1 read
    wr(32'h0000_0000, 32'hCAFE_F00D, 4'hF);
    wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    addr = 32'h10; rreq = 1'b1;
    cyc();
    rreq = 1'b0;
    check("t1_rack",  {31'b0, rack1}, 32'h1);
    check("t1_rdata", rdata1, 32'hDEAD_BEEF);
    cyc();
    check("t1_rack_drop",  {31'b0, rack1}, 32'h0);
    check("t1_rdata_zero", rdata1, 32'h0);
    repeat (4) cyc();

    // 2: byte-lane write, then latency measurement with rreq held across two edges
    wr(32'h0000_0010, 32'h0000_AB00, 4'b0010);
    addr = 32'h10; rreq = 1'b1;
    n3 = 0; n4 = 0; p1 = 0; p3 = 0; v3 = '0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 2) rreq = 1'b0;
      if (rack1) p1++;
      if (rack3) begin p3++; if (n3 == 0) begin n3 = i; v3 = rdata3; end end
      if (rack4 && n4 == 0) n4 = i;
    end
    check("t2_lat3",        n3, 3);
    check("t2_rdata3",      v3, 32'hDEAD_ABEF);
    check("t2_rack3_once",  p3, 1);
    check("t2_lat4",        n4, 4);
    check("t2_b2b_lat1",    p1, 2);

    // 3: console FIFO overflow and ordering
    for (int i = 1; i <= 4; i++) wr(CON, 32'(i), 4'hF);
    check("t3_no_ovf_at_full", {31'b0, overflow1}, 32'h0);
    wr(CON, 32'h5, 4'hF);
    check("t3_overflow", {31'b0, overflow1}, 32'h1);
    rd1(CON, v, ack);
    check("t3_con_status", v, 32'h0000_0401);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t3_valid_%0d", i), {31'b0, con_valid1}, 32'h1);
      check($sformatf("t3_pop_%0d", i), con_data1, 32'(i));
      con_ready = 1'b1;
      cyc();
    end
    con_ready = 1'b0;
    check("t3_empty", {31'b0, con_valid1}, 32'h0);

    // 4: halt latches first code only
    wr(HLT, 32'h2A, 4'hF);
    wr(HLT, 32'h7, 4'hF);
    check("t4_halt",      {31'b0, halt1}, 32'h1);
    check("t4_halt_code", halt_code1, 32'h2A);
    rd1(HLT, v, ack);
    check("t4_rd_ack",  {31'b0, ack}, 32'h1);
    check("t4_rd_halt", v, 32'h0000_002A);

    // 5: unmapped access
    check("t5_no_err_yet", {31'b0, bus_err1}, 32'h0);
    rd1(32'h0010_0000, v, ack);
    check("t5_ack",     {31'b0, ack}, 32'h1);
    check("t5_rdata",   v, 32'h0);
    check("t5_bus_err", {31'b0, bus_err1}, 32'h1);
    wr(32'h0010_0000, 32'h1234_5678, 4'hF);
    rd1(32'h0000_0000, v, ack);
    check("t5_ram_kept", v, 32'hCAFE_F00D);

    // 6: reset while the latency-4 target is waiting
    addr = 32'h10; rreq = 1'b1;
    cyc();
    rreq = 1'b0;
    cyc();
    reset_n = 1'b0;
    #1;
    check("t6_rack",      {31'b0, rack4}, 32'h0);
    check("t6_rdata",     rdata4, 32'h0);
    check("t6_halt",      {31'b0, halt4}, 32'h0);
    check("t6_halt_code", halt_code4, 32'h0);
    check("t6_overflow",  {31'b0, overflow4}, 32'h0);
    check("t6_bus_err",   {31'b0, bus_err4}, 32'h0);
    check("t6_con_valid", {31'b0, con_valid4}, 32'h0);
    cyc(); cyc();
    reset_n = 1'b1;
    p4 = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (rack4) p4++;
    end
    check("t6_no_stale_rack", p4, 0);
    addr = 32'h10; rreq = 1'b1;
    n4 = 0; v4 = '0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      rreq = 1'b0;
      if (rack4 && n4 == 0) begin n4 = i; v4 = rdata4; end
    end
    check("t6_post_lat4",  n4, 4);
    check("t6_ram_kept",   v4, 32'hDEAD_ABEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
